// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit and receive paths:
//   - tx_state_e     : transmitter frame states
//   - PARITY_EVEN/ODD: encodings of the parity_type control bit
//   - UART_DATA_BITS : data bits per frame (fixed at 8)
//   - calc_parity()  : parity bit for a byte, shared with the RX parity checker
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int   UART_DATA_BITS = 8;
    localparam logic PARITY_EVEN    = 1'b0;
    localparam logic PARITY_ODD     = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Even parity (0): the bit makes the total count of ones even.
    // Odd parity (1): the bit makes the total count of ones odd.
    function automatic logic calc_parity(input logic [UART_DATA_BITS-1:0] data,
                                         input logic                      parity_type);
        return (^data) ^ parity_type;
    endfunction

endpackage : uart_pkg

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. Reusable by the receiver.
// Ports:
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   clear : restart the bit period (count returns to 0 next cycle)
//   tick  : high during the last cycle of the current bit period
// -----------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the values from before the edge, regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : baud_tick_gen

// File: rtl/uart_tx_parity.sv
// -----------------------------------------------------------------------------
// uart_tx_parity
// 8-bit UART transmitter: start bit, 8 data bits LSB-first, optional parity
// bit, one stop bit. Every bit lasts CLKS_PER_BIT clocks. All outputs are
// registered.
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   tx_start    : one-cycle send request, honoured only when idle
//   tx_data     : byte to send, captured on acceptance
//   parity_en   : 1 = append parity bit, captured on acceptance
//   parity_type : 0 = even, 1 = odd, captured on acceptance
//   tx          : serial line, idles high
//   tx_busy     : high while a frame is on the line
//   tx_done     : one-cycle pulse when the stop bit completes
// -----------------------------------------------------------------------------
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 parity_en,
    input  logic                 parity_type,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic tick;
    logic baud_clear;

    // The bit period restarts on every state change; holding it clear while
    // idle makes the start bit begin from count 0.
    assign baud_clear = (state_q == IDLE) || (state_d != state_q);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (tick)
    );

    // Outputs are computed for the state being entered, so tx changes on the
    // same edge as the state.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_start) begin
                    shift_d   = tx_data;
                    par_en_d  = parity_en;
                    par_bit_d = calc_parity(tx_data, parity_type);
                    bit_idx_d = '0;
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = par_en_q ? PARITY : STOP;
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        // Next bit is shift_q[1], i.e. bit 0 after the shift.
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule : uart_tx_parity

// File: tb/tb_uart_tx_parity.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_parity
// Self-checking bench for uart_tx_parity with CLKS_PER_BIT = 4. Expected line
// levels come from a frame model: list of bit values built from the byte, a
// ones count for parity, and a fixed bit width.
// -----------------------------------------------------------------------------
module tb_uart_tx_parity;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       parity_en;
    logic       parity_type;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int errors = 0;
    int checks = 0;

    uart_tx_parity #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .parity_en  (parity_en),
        .parity_type(parity_type),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame model: start(0), data LSB first, optional parity, stop(1).
    task automatic build_frame(input logic [7:0] data, input logic pe, input logic pt,
                               output logic bits[$]);
        int ones;
        bits = {};
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            bits.push_back(data[i]);
            if (data[i]) ones++;
        end
        if (pe) begin
            // Even: total ones (data + parity) even. Odd: total ones odd.
            if (pt) bits.push_back((ones % 2) == 0);
            else    bits.push_back((ones % 2) == 1);
        end
        bits.push_back(1'b1);
    endtask

    task automatic request(input logic [7:0] data, input logic pe, input logic pt);
        tx_start    = 1'b1;
        tx_data     = data;
        parity_en   = pe;
        parity_type = pt;
    endtask

    // Expects a request to be pending. Checks every cycle of the frame and the
    // tx_done cycle. With chain=1 the next request is raised during tx_done.
    // At disturb_k a request with other data and flipped parity settings is
    // raised mid-frame; it must have no effect.
    task automatic run_frame(input logic [7:0] data, input logic pe, input logic pt,
                             input string tag, input int disturb_k, input bit chain,
                             input logic [7:0] n_data, input logic n_pe, input logic n_pt);
        logic bits[$];
        int   len;
        build_frame(data, pe, pt, bits);
        len = bits.size() * CPB;
        step();
        tx_start = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (k == disturb_k) begin
                tx_start    = 1'b1;
                tx_data     = 8'h55;
                parity_en   = ~pe;
                parity_type = ~pt;
            end else if (k == disturb_k + 1) begin
                tx_start = 1'b0;
            end
            checks++;
            if (tx !== bits[k / CPB]) begin
                errors++;
                $display("FAIL %s tx cycle=%0d bit=%0d got=%b exp=%b", tag, k, k / CPB, tx, bits[k / CPB]);
            end
            checks++;
            if (tx_busy !== 1'b1 || tx_done !== 1'b0) begin
                errors++;
                $display("FAIL %s busy/done cycle=%0d got=%b/%b exp=1/0", tag, k, tx_busy, tx_done);
            end
            step();
        end
        checks++;
        if (tx_done !== 1'b1 || tx_busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL %s done cycle=%0d got done/busy/tx=%b/%b/%b exp=1/0/1",
                     tag, len, tx_done, tx_busy, tx);
        end
        if (chain) begin
            request(n_data, n_pe, n_pt);
        end else begin
            tx_start = 1'b0;
            step();
            checks++;
            if (tx_done !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0) begin
                errors++;
                $display("FAIL %s after-done got done/busy/tx=%b/%b/%b exp=0/0/1",
                         tag, tx_done, tx_busy, tx);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tx_start = 1'b0; tx_data = 8'h00; parity_en = 1'b0; parity_type = 1'b0;
        step();
        step();
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got tx/busy/done=%b/%b/%b exp=1/0/0", tx, tx_busy, tx_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle=%0d got tx/busy/done=%b/%b/%b exp=1/0/0",
                         i, tx, tx_busy, tx_done);
            end
        end
    endtask

    task automatic test_known_frames();
        request(8'h01, 1'b1, 1'b0); run_frame(8'h01, 1'b1, 1'b0, "h01_even", -1, 1'b0, 8'h00, 1'b0, 1'b0);
        request(8'h0F, 1'b1, 1'b1); run_frame(8'h0F, 1'b1, 1'b1, "h0F_odd",  -1, 1'b0, 8'h00, 1'b0, 1'b0);
        request(8'h1F, 1'b1, 1'b1); run_frame(8'h1F, 1'b1, 1'b1, "h1F_odd",  -1, 1'b0, 8'h00, 1'b0, 1'b0);
        request(8'hFF, 1'b1, 1'b0); run_frame(8'hFF, 1'b1, 1'b0, "hFF_even", -1, 1'b0, 8'h00, 1'b0, 1'b0);
        request(8'hAA, 1'b1, 1'b1); run_frame(8'hAA, 1'b1, 1'b1, "hAA_odd",  -1, 1'b0, 8'h00, 1'b0, 1'b0);
        request(8'hA5, 1'b0, 1'b0); run_frame(8'hA5, 1'b0, 1'b0, "hA5_nopar", -1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            logic       pe;
            logic       pt;
            d  = 8'($urandom_range(255));
            pe = 1'($urandom_range(1));
            pt = 1'($urandom_range(1));
            request(d, pe, pt);
            run_frame(d, pe, pt, "random", -1, 1'b0, 8'h00, 1'b0, 1'b0);
        end
    endtask

    // 8'h33 frame with a mid-frame request during data bit 3 (cycles 16..19),
    // chained back-to-back into a random frame requested during tx_done.
    task automatic test_back_to_back();
        logic [7:0] d2;
        d2 = 8'($urandom_range(255));
        request(8'h33, 1'b1, 1'b0);
        run_frame(8'h33, 1'b1, 1'b0, "busy_ignore", 16, 1'b1, d2, 1'b1, 1'b1);
        run_frame(d2, 1'b1, 1'b1, "back_to_back", 20, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Reset asserted during data bit 5 (cycles 24..27).
    task automatic test_reset_mid_frame();
        logic [7:0] d;
        d = 8'h00;
        request(8'h00, 1'b1, 1'b1);
        step();
        tx_start = 1'b0;
        for (int k = 0; k < 25; k++) step();
        rst = 1'b1;
        #1;
        checks++;
        if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got tx/busy/done=%b/%b/%b exp=1/0/0", tx, tx_busy, tx_done);
        end
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_resume cycle=%0d got tx/busy/done=%b/%b/%b exp=1/0/0",
                         i, tx, tx_busy, tx_done);
            end
        end
        d = 8'($urandom_range(255));
        request(d, 1'b1, 1'b0);
        run_frame(d, 1'b1, 1'b0, "after_reset", -1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_known_frames();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_tx_parity

// File: doc/uart_tx_parity.md
Name: uart_tx_parity

Overview:
Serial transmitter for the 8-bit UART. It accepts one byte on a start strobe and emits a frame LSB-first on the tx line: start bit, 8 data bits, an optional parity bit, then one stop bit. Parity generation uses the same convention as the receive-side parity checker: parity_type 0 selects even parity, 1 selects odd. The block sits between the host-side byte interface and the TX pad, mirroring the RX path.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (e.g. 100 MHz / 115200); legal range ≥2
DATA_BITS, 8, data bits per frame; fixed at 8 for this UART

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
tx_start  input  1  one-cycle request to send tx_data; sampled only in IDLE
tx_data  input  8  byte to send; captured when the start request is accepted
parity_en  input  1  1 = insert parity bit; captured with tx_data
parity_type  input  1  0 = even, 1 = odd; captured with tx_data
tx  output  1  serial line; idles high
tx_busy  output  1  high while a frame is in progress
tx_done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset (async assert, any state): state=IDLE, tx=1, tx_busy=0, tx_done=0, baud counter=0, bit index=0, shift register=0.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE: tx=1, tx_busy=0. When tx_start=1, capture tx_data, parity_en and parity_type, compute parity_bit = ^tx_data XOR parity_type, and go to START. On the next cycle tx=0 and tx_busy=1.
- Each of START, DATA, PARITY and STOP holds tx for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1 and clears on every state change.
- START → DATA. DATA drives shift_reg[0], shifts right once per bit, and repeats for 8 bits (bit index 0..7).
- After bit 7: go to PARITY if the captured parity_en=1, otherwise go to STOP.
- PARITY: tx=parity_bit, then STOP. STOP: tx=1.
- At the last cycle of STOP: return to IDLE, tx_busy=0, and tx_done=1 for exactly one cycle.
- Frame length: 11×CLKS_PER_BIT cycles with parity, 10×CLKS_PER_BIT without.
- tx_start while busy: ignored, not queued.
- tx_data, parity_en or parity_type changing mid-frame: no effect, because all three are captured at acceptance.
- tx_start asserted in the cycle tx_done is high: accepted, since the block is in IDLE. Back-to-back frames therefore have no extra idle gap beyond the stop bit.
- Reset mid-frame: the line returns high immediately, with no tx_done and no partial frame resumed.
- Parity check: for the same byte and parity_type, the transmitted parity bit must make the receive-side parity checker report parity_ok=1.

Decomposition:
- Shared package uart_pkg holds:
  - the tx state enum (IDLE/START/DATA/PARITY/STOP);
  - constants PARITY_EVEN=1'b0 and PARITY_ODD=1'b1;
  - UART_DATA_BITS=8;
  - a function calc_parity(data, type) shared with the receive-side checker.
- One sub-module is natural: baud_tick_gen (counter with parameter CLKS_PER_BIT, inputs clk, rst and clear, output tick on the last cycle of each bit). It is reusable by the receiver.

Test Plan:
- Bench uses CLKS_PER_BIT=4.
- Reset: hold rst=1 → tx=1, tx_busy=0, tx_done=0. Release rst and wait 20 cycles with tx_start=0 → tx remains 1.
- 8'h01, parity_en=1, parity_type=0 (even) → tx sequence 0,1,0,0,0,0,0,0,0,1,1, each bit held 4 cycles. tx_done pulses at cycle 44 after acceptance, and tx_busy is high for 44 cycles.
- 8'h0F, parity_type=1 (odd) → parity bit=1. 8'h1F, parity_type=1 → parity bit=0. 8'hFF, even → 0. 8'hAA, odd → 1.
- 8'hA5, parity_en=0 → frame 0,1,0,1,0,0,1,0,1,1 with no parity slot. tx_done at cycle 40.
- Busy and back-to-back:
  - Pulse tx_start with 8'h55 at data bit 3 of a frame carrying 8'h33 → ignored; the 8'h33 frame is unchanged.
  - Then assert tx_start together with tx_done → the next start bit follows the stop bit directly.
  - Changing parity_type mid-frame does not alter the parity bit.
- Reset mid-frame: assert rst during data bit 5 → tx=1 and tx_busy=0 asynchronously, with no tx_done. A new frame after release is correct.
